uart_rx_frame: RTL and testbench

//  UART receive-side frame engine; the counterpart of the TX serializer and parity generator.

---
 rtl/uart_rx_frame_if.sv | 25 ++
 rtl/uart_rx_frame.sv | 142 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_if.sv
// Signal bundle between the RX line/config source and the UART receive frame engine.
// master drives the line and configuration; slave is the frame engine.
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_IN;
    logic [PRESC_W-1:0]    Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  Par_err;
    logic                  Stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_valid, Par_err, Stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_valid, Par_err, Stp_err
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: start detect, 3-sample majority vote, LSB-first deserialize,
// parity and stop checking, one-cycle result pulses with P_DATA held between good frames.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_frame_if.slave bus
);
    localparam int BC_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                r_state;
    logic [PRESC_W-1:0]    r_edge_cnt;
    logic [BC_W-1:0]       r_bit_cnt;
    logic [PRESC_W-1:0]    r_presc;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_flag;
    logic                  r_s0;
    logic                  r_s1;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_pdata;
    logic                  r_dv;
    logic                  r_pe;
    logic                  r_se;

    logic [PRESC_W-1:0] w_half;
    logic               w_smp0;
    logic               w_smp1;
    logic               w_dec;
    logic               w_last;
    logic               w_bit;
    logic               w_par_exp;

    // The third sample is the live line value at the decision edge.
    assign w_half    = r_presc >> 1;
    assign w_smp0    = (r_edge_cnt == w_half - PRESC_W'(1));
    assign w_smp1    = (r_edge_cnt == w_half);
    assign w_dec     = (r_edge_cnt == w_half + PRESC_W'(1));
    assign w_last    = (r_edge_cnt == r_presc - PRESC_W'(1));
    assign w_bit     = (r_s0 & r_s1) | (r_s0 & bus.RX_IN) | (r_s1 & bus.RX_IN);
    assign w_par_exp = r_par_typ ? ~^r_shift : ^r_shift;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_presc    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_flag <= 1'b0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_shift    <= '0;
            r_pdata    <= '0;
            r_dv       <= 1'b0;
            r_pe       <= 1'b0;
            r_se       <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            r_pe <= 1'b0;
            r_se <= 1'b0;
            if (w_smp0) r_s0 <= bus.RX_IN;
            if (w_smp1) r_s1 <= bus.RX_IN;
            case (r_state)
                IDLE: begin
                    if (!bus.RX_IN) begin
                        r_state    <= START;
                        r_edge_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_presc    <= bus.Prescale;
                        r_par_en   <= bus.PAR_EN;
                        r_par_typ  <= bus.PAR_TYP;
                        r_par_flag <= 1'b0;
                    end
                end
                START: begin
                    if (w_dec && w_bit) begin
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_state    <= DATA;
                        r_edge_cnt <= '0;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
                    end
                end
                DATA: begin
                    if (w_dec) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                    if (w_last) begin
                        r_edge_cnt <= '0;
                        if (r_bit_cnt == BC_W'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
                    end
                end
                PARITY: begin
                    if (w_dec && (w_bit != w_par_exp)) r_par_flag <= 1'b1;
                    if (w_last) begin
                        r_state    <= STOP;
                        r_edge_cnt <= '0;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
                    end
                end
                STOP: begin
                    // Leave mid stop bit so a start bit right after it is not missed.
                    if (w_dec) begin
                        r_state <= DONE;
                        if (!w_bit || r_par_flag) begin
                            r_pe <= r_par_flag;
                            r_se <= ~w_bit;
                        end else begin
                            r_dv    <= 1'b1;
                            r_pdata <= r_shift;
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_edge_cnt <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.P_DATA     = r_pdata;
    assign bus.Data_valid = r_dv;
    assign bus.Par_err    = r_pe;
    assign bus.Stp_err    = r_se;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames driven bit by bit, result pulses timed
// relative to the start-detect edge and compared against hand-computed values.
module tb_uart_rx_frame;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_rx_frame_if #(.DATA_WIDTH(8), .PRESC_W(6)) bus ();

    uart_rx_frame #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0    = 0;

    int n_dv = 0, n_pe = 0, n_se = 0;
    int dv_cyc = 0, pe_cyc = 0, se_cyc = 0;
    logic [7:0] dv_dat = 8'h00;
    int s_dv, s_pe, s_se;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.Data_valid) begin n_dv++; dv_cyc = cyc; dv_dat = bus.P_DATA; end
        if (bus.Par_err)    begin n_pe++; pe_cyc = cyc; end
        if (bus.Stp_err)    begin n_se++; se_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_dv = n_dv; s_pe = n_pe; s_se = n_se;
    endtask

    task automatic drive_bit(input logic b, input int p, input bit flip);
        for (int c = 0; c < p; c++) begin
            bus.RX_IN = (flip && c == p / 2 + 1) ? ~b : b;
            @(negedge CLK);
        end
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Start, 8 data bits LSB-first, optional parity, stop. noise = frame bit index to
    // corrupt on its middle sample only (-1 for none).
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input logic pbit, input logic sbit, input int noise);
        bus.Prescale = 6'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        t0 = cyc + 1;
        drive_bit(1'b0, p, noise == 0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, noise == i + 1);
        if (pen) drive_bit(pbit, p, 1'b0);
        drive_bit(sbit, p, 1'b0);
    endtask

    initial begin
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_pdata", 32'(bus.P_DATA), 32'h0);
        chk("rst_dv",    32'(bus.Data_valid), 32'h0);
        chk("rst_pe",    32'(bus.Par_err), 32'h0);
        chk("rst_se",    32'(bus.Stp_err), 32'h0);
        RST = 1'b0;
        idle(4);

        // 1: good frame with even parity
        snap();
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        chk("t1_dv_cnt", 32'(n_dv - s_dv), 32'd1);
        chk("t1_dv_at",  32'(dv_cyc - t0), 32'd86);
        chk("t1_data",   32'(dv_dat), 32'hA5);
        chk("t1_err",    32'(n_pe - s_pe + n_se - s_se), 32'd0);

        // 2: wrong parity bit
        snap();
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle(4);
        chk("t2_pe_cnt", 32'(n_pe - s_pe), 32'd1);
        chk("t2_pe_at",  32'(pe_cyc - t0), 32'd86);
        chk("t2_dv_cnt", 32'(n_dv - s_dv), 32'd0);
        chk("t2_se_cnt", 32'(n_se - s_se), 32'd0);
        chk("t2_pdata",  32'(bus.P_DATA), 32'hA5);

        // 3: P=16, no parity, stop bit 0; the low stop bit re-arms as a glitch
        snap();
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(48);
        chk("t3_se_cnt", 32'(n_se - s_se), 32'd1);
        chk("t3_se_at",  32'(se_cyc - t0), 32'd154);
        chk("t3_dv_cnt", 32'(n_dv - s_dv), 32'd0);
        chk("t3_pe_cnt", 32'(n_pe - s_pe), 32'd0);

        // both errors in one frame
        snap();
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        idle(32);
        chk("tb_pe_at",  32'(pe_cyc - t0), 32'd86);
        chk("tb_se_at",  32'(se_cyc - t0), 32'd86);
        chk("tb_dv_cnt", 32'(n_dv - s_dv), 32'd0);

        // 4: two-cycle glitch, then a good frame
        snap();
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        repeat (2) @(negedge CLK);
        idle(20);
        chk("t4_glitch", 32'(n_dv - s_dv + n_pe - s_pe + n_se - s_se), 32'd0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        chk("t4_dv_cnt", 32'(n_dv - s_dv), 32'd1);
        chk("t4_dv_at",  32'(dv_cyc - t0), 32'd78);
        chk("t4_data",   32'(dv_dat), 32'h5A);

        // 5: P=32 odd parity, back-to-back, one noisy sample per frame
        snap();
        send_frame(8'h00, 32, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        chk("t5a_dv_at", 32'(dv_cyc - t0), 32'd338);
        chk("t5a_data",  32'(dv_dat), 32'h00);
        send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b1, 1'b1, 3);
        idle(8);
        chk("t5b_dv_at", 32'(dv_cyc - t0), 32'd338);
        chk("t5b_data",  32'(dv_dat), 32'hFF);
        chk("t5_dv_cnt", 32'(n_dv - s_dv), 32'd2);
        chk("t5_err",    32'(n_pe - s_pe + n_se - s_se), 32'd0);

        // 6: reset mid-DATA, then a clean frame
        snap();
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b1, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        RST       = 1'b1;
        bus.RX_IN = 1'b1;
        @(posedge CLK);
        #1;
        chk("t6_pdata", 32'(bus.P_DATA), 32'h0);
        chk("t6_flags", 32'({bus.Data_valid, bus.Par_err, bus.Stp_err}), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        idle(100);
        chk("t6_quiet", 32'(n_dv - s_dv + n_pe - s_pe + n_se - s_se), 32'd0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        chk("t6_dv_at", 32'(dv_cyc - t0), 32'd78);
        chk("t6_data",  32'(dv_dat), 32'h81);
        chk("t6_dv_cnt", 32'(n_dv - s_dv), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
